// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   NIBBLE_W    : width of one hex digit
//   ANODE_OFF   : anode level that turns a digit off (common anode, active-low enable)
//   MAX_DIGITS  : widest display the digit-slice helper supports
//   digit_slice : returns nibble 'idx' of a packed hex value (digit 0 = LS nibble)
package display_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam logic        ANODE_OFF  = 1'b1;
  localparam int unsigned MAX_DIGITS = 16;

  // Callers zero-extend their value to the full MAX_DIGITS width first.
  function automatic logic [NIBBLE_W-1:0] digit_slice(
    input logic [NIBBLE_W*MAX_DIGITS-1:0] val,
    input int unsigned                    idx
  );
    return val[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: free-running counter 0..PRESCALE-1.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset, clears the counter
//   cnt_o  : current position inside the slot
//   tick_o : high in the last cycle of a slot (cnt_o == PRESCALE-1)
module scan_prescaler #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CntW     = $clog2(PRESCALE)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [CntW-1:0] cnt_o,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  assign tick = (cnt_q == CntW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tick_o = tick;

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
// A loaded value is held in a pending buffer and copied to the display buffer only at
// the frame wrap, so a single frame never mixes digits of two values.
//   clk_i         : system clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   value_i       : packed hex value, value_i[4i+3:4i] = digit i
//   load_i        : 1-cycle strobe, captures value_i into the pending buffer
//   nibble_o      : nibble of the digit in the current slot (always driven)
//   anode_o       : active-low one-hot digit enable, all ones = dark
//   pending_o     : a loaded value is waiting for the frame boundary
//   frame_start_o : first cycle of the digit-0 slot
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned PRESCALE      = 50000,
  parameter int unsigned DEAD          = 2,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NIBBLE_W*DIGITS-1:0]   value_i,
  input  logic                         load_i,
  output logic [NIBBLE_W-1:0]          nibble_o,
  output logic [DIGITS-1:0]            anode_o,
  output logic                         pending_o,
  output logic                         frame_start_o
);

  localparam int unsigned ValW = NIBBLE_W * DIGITS;
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned ExtW = NIBBLE_W * MAX_DIGITS;

  logic [CntW-1:0] cnt;
  logic            tick;
  logic            frame_wrap;
  logic            past_dead;

  logic [IdxW-1:0] idx_q, idx_d;
  logic [ValW-1:0] disp_q, disp_d;
  logic [ValW-1:0] pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;

  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] anode;
  logic              upper_nz;
  logic [ExtW-1:0]   disp_ext;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .CntW     (CntW)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cnt_o  (cnt),
    .tick_o (tick)
  );

  assign frame_wrap = tick && (idx_q == IdxW'(DIGITS - 1));

  // Dead time at slot start keeps the previous digit's segments from ghosting.
  if (DEAD == 0) begin : gen_no_dead
    assign past_dead = 1'b1;
  end else begin : gen_dead
    assign past_dead = (cnt >= CntW'(DEAD));
  end

  // Digit index advances on every slot tick.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Double buffer. Swap happens first, so a load on the wrap tick refills pending
  // after the old pending value has moved into the display buffer.
  always_comb begin
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (frame_wrap && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load_i) begin
      pend_d       = value_i;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Digit i>0 is blanked when it and every more significant digit are zero.
  always_comb begin
    blank    = '0;
    upper_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_nz = upper_nz | (disp_q[i*NIBBLE_W +: NIBBLE_W] != '0);
      blank[i] = BLANK_LEADING && !upper_nz;
    end
  end

  always_comb begin
    anode = {DIGITS{ANODE_OFF}};
    for (int i = 0; i < DIGITS; i++) begin
      if ((idx_q == IdxW'(i)) && past_dead && !blank[i]) begin
        anode[i] = ~ANODE_OFF;
      end
    end
  end

  assign disp_ext      = ExtW'(disp_q);
  assign nibble_o      = digit_slice(disp_ext, 32'(idx_q));
  assign anode_o       = anode;
  assign pending_o     = pend_valid_q;
  assign frame_start_o = (idx_q == '0) && (cnt == '0);

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;

  localparam int D    = 4;
  localparam int P    = 4;
  localparam int F    = D * P;
  localparam int NCFG = 3;

  // Three configurations share one stimulus stream.
  int dead_c[NCFG]  = '{1, 0, 3};
  bit blank_c[NCFG] = '{1'b1, 1'b0, 1'b1};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] value = '0;

  logic [3:0] nib [NCFG];
  logic [3:0] an  [NCFG];
  logic       pnd [NCFG];
  logic       fs  [NCFG];

  display_scan_driver #(
    .DIGITS(D), .PRESCALE(P), .DEAD(1), .BLANK_LEADING(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .load_i(load),
    .nibble_o(nib[0]), .anode_o(an[0]), .pending_o(pnd[0]), .frame_start_o(fs[0])
  );

  display_scan_driver #(
    .DIGITS(D), .PRESCALE(P), .DEAD(0), .BLANK_LEADING(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .load_i(load),
    .nibble_o(nib[1]), .anode_o(an[1]), .pending_o(pnd[1]), .frame_start_o(fs[1])
  );

  display_scan_driver #(
    .DIGITS(D), .PRESCALE(P), .DEAD(3), .BLANK_LEADING(1'b1)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .load_i(load),
    .nibble_o(nib[2]), .anode_o(an[2]), .pending_o(pnd[2]), .frame_start_o(fs[2])
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCFG-1:0][3:0] nib;
    logic [NCFG-1:0][3:0] an;
    logic                 pend;
    logic                 fs;
  } exp_t;

  exp_t sb[$];

  int total  = 0;
  int passed = 0;

  // Reference model: time since reset plus the shown/pending values.
  int          t;
  logic [15:0] shown;
  logic [15:0] pend_v;
  bit          pv;

  task automatic check(input string nm, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s cfg%0d at t=%0d: got %h expected %h", nm, k, t, act, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t        e;
    int          slot;
    int          c;
    logic [15:0] upper;
    bit          blanked;
    slot  = (t / P) % D;
    c     = t % P;
    upper = shown >> (4 * slot);
    for (int k = 0; k < NCFG; k++) begin
      e.nib[k] = upper[3:0];
      blanked  = blank_c[k] && (slot > 0) && (upper == 16'h0);
      e.an[k]  = 4'hf;
      if (c >= dead_c[k] && !blanked) e.an[k][slot] = 1'b0;
    end
    e.pend = pv;
    e.fs   = ((t % F) == 0);
    return e;
  endfunction

  task automatic model_reset();
    t      = 0;
    shown  = '0;
    pend_v = '0;
    pv     = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] v);
    if ((t % F) == F - 1 && pv) begin
      shown = pend_v;
      pv    = 1'b0;
    end
    if (ld) begin
      pend_v = v;
      pv     = 1'b1;
    end
    t++;
  endtask

  task automatic step(input bit ld, input logic [15:0] v);
    load  = ld;
    value = v;
    @(posedge clk);
    #1;
    model_edge(ld, v);
    load = 1'b0;
    sb.push_back(predict());
  endtask

  task automatic goto_phase(input int ph);
    while ((t % F) != ph) step(1'b0, 16'h0);
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < NCFG; k++) begin
          check("nibble", k, 16'(nib[k]), 16'(e.nib[k]));
          check("anode", k, 16'(an[k]), 16'(e.an[k]));
          check("pending", k, 16'(pnd[k]), 16'(e.pend));
          check("frame_start", k, 16'(fs[k]), 16'(e.fs));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] masks[5];
    masks = '{16'h0000, 16'h000f, 16'h00ff, 16'h0fff, 16'hffff};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(predict());

    // Idle scan after reset: only digit 0 lit, blanked elsewhere.
    repeat (34) step(1'b0, 16'h0);

    // Load mid-frame in slot 2, takes effect at the wrap.
    goto_phase(8);
    step(1'b1, 16'h1234);
    goto_phase(0);
    repeat (F + 4) step(1'b0, 16'h0);

    // Leading-zero blanking pattern.
    step(1'b1, 16'h0050);
    repeat (2 * F) step(1'b0, 16'h0);

    // Load on the wrap tick while a value is already pending.
    step(1'b1, 16'h1111);
    goto_phase(F - 1);
    step(1'b1, 16'h2222);
    repeat (2 * F) step(1'b0, 16'h0);

    step(1'b1, 16'h0008);
    repeat (2 * F) step(1'b0, 16'h0);

    // Asynchronous reset at idx=2, cnt=2 with a value pending.
    step(1'b1, 16'hbeef);
    goto_phase(9);
    load = 1'b0;
    @(posedge clk);
    #2;
    model_edge(1'b0, 16'h0);
    rst_n = 1'b0;
    model_reset();
    sb.push_back(predict());
    @(posedge clk);
    #1;
    sb.push_back(predict());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(predict());
    repeat (F + 2) step(1'b0, 16'h0);

    // Randomised loads with values biased towards leading zeros.
    repeat (1500) begin
      bit          ld;
      logic [15:0] v;
      ld = ($urandom_range(0, 9) == 0);
      v  = 16'($urandom) & masks[$urandom_range(0, 4)];
      step(ld, v);
    end

    @(negedge clk);
    #1;
    check("drain", 0, 16'(sb.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
